// File: rtl/decode_byte_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : DecoderTypes
// Description : Shared types and sizes for the decode byte sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package DecoderTypes;

    localparam int MAX_INS_BYTES = 15;
    localparam int FETCH_BYTES   = 8;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [1:0]  map;
        logic        has_modrm;
        logic [7:0]  modrm;
        logic [3:0]  prefix_len;
        logic [31:0] disp;
        logic [63:0] imm;
    } fat_instruction_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/decode_byte_sequencer_buffer.sv
`default_nettype none
// ============================================================================
// Module      : byte_shift_buffer
// Description : Byte FIFO with variable left shift and contiguous beat append.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_shift_buffer #(
    parameter  int BUF_BYTES   = 32,
    parameter  int FETCH_BYTES = 8,
    parameter  int MAX_INS     = 15,
    localparam int CNT_W       = $clog2(BUF_BYTES + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     pop_en,
    input  logic [3:0]               pop_len,
    input  logic                     push_en,
    input  logic [FETCH_BYTES*8-1:0] push_data,
    output logic [CNT_W-1:0]         count,
    output logic [MAX_INS*8-1:0]     head_bytes
);
    import DecoderTypes::*;

    localparam int IDX_W = $clog2(BUF_BYTES);
    localparam int BW    = $clog2(FETCH_BYTES);

    logic [7:0]       mem_q [BUF_BYTES];
    logic [7:0]       mem_d [BUF_BYTES];
    logic [7:0]       beat  [FETCH_BYTES];
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] shift_amt, keep;
    int               src_idx, app_idx;

    for (genvar b = 0; b < FETCH_BYTES; b++) begin : g_beat
        assign beat[b] = push_data[(FETCH_BYTES-1-b)*8 +: 8];
    end

    // Bytes past count are always kept at zero so the head window is zero-padded.
    always_comb begin
        shift_amt = pop_en ? CNT_W'(pop_len) : '0;
        keep      = count_q - shift_amt;
        count_d   = keep + (push_en ? CNT_W'(FETCH_BYTES) : '0);
        src_idx   = 0;
        app_idx   = 0;
        for (int i = 0; i < BUF_BYTES; i++) begin
            mem_d[i] = 8'h00;
            src_idx  = i + int'(shift_amt);
            app_idx  = i - int'(keep);
            if (src_idx < int'(count_q)) begin
                mem_d[i] = mem_q[src_idx[IDX_W-1:0]];
            end else if (push_en && app_idx >= 0 && app_idx < FETCH_BYTES) begin
                mem_d[i] = beat[app_idx[BW-1:0]];
            end
        end
        if (flush) begin
            count_d = '0;
            for (int i = 0; i < BUF_BYTES; i++) begin
                mem_d[i] = 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < BUF_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < BUF_BYTES; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    for (genvar g = 0; g < MAX_INS; g++) begin : g_head
        assign head_bytes[(MAX_INS-1-g)*8 +: 8] = mem_q[g];
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/decode_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : decode_byte_sequencer
// Description : Feeds byte windows to the x86 decoder, tracks PC, registers output.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_byte_sequencer #(
    parameter int BUF_BYTES   = 32,
    parameter int FETCH_BYTES = 8,
    parameter int MAX_INS     = 15
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            redirect,
    input  logic [63:0]                     redirect_pc,
    input  logic [FETCH_BYTES*8-1:0]        fetch_data,
    input  logic                            fetch_valid,
    output logic                            fetch_ready,
    output logic [MAX_INS*8-1:0]            win_bytes,
    output logic [5:0]                      win_count,
    input  logic                            dec_need_more,
    input  logic                            dec_err,
    input  logic [3:0]                      dec_len,
    input  DecoderTypes::fat_instruction_t  dec_ins,
    output logic                            ins_valid,
    input  logic                            ins_ready,
    output DecoderTypes::fat_instruction_t  ins_out,
    output logic [63:0]                     ins_pc,
    output logic [3:0]                      ins_len,
    output logic                            halted
);
    import DecoderTypes::*;

    localparam int CNT_W = $clog2(BUF_BYTES + 1);

    seq_state_t       state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic             ins_valid_q, ins_valid_d;
    fat_instruction_t ins_out_q, ins_out_d;
    logic [63:0]      ins_pc_q, ins_pc_d;
    logic [3:0]       ins_len_q, ins_len_d;

    logic [CNT_W-1:0] count;
    logic             push, out_free, can_dec, len_bad, fire, fault;

    assign fetch_ready = ({1'b0, count} + (CNT_W+1)'(FETCH_BYTES)) <= (CNT_W+1)'(BUF_BYTES);
    assign push        = fetch_valid && fetch_ready && !redirect;
    assign out_free    = !ins_valid_q || ins_ready;
    assign can_dec     = (state_q == RUN) && (count != '0) && out_free && !redirect;
    assign len_bad     = (dec_len == 4'd0) || (CNT_W'(dec_len) > count);

    // A decoder still asking for bytes with a full window can never make progress.
    assign fault = can_dec && (dec_err
                               || (dec_need_more && count >= CNT_W'(MAX_INS))
                               || (!dec_need_more && len_bad));
    assign fire  = can_dec && !dec_need_more && !dec_err && !len_bad;

    byte_shift_buffer #(
        .BUF_BYTES   (BUF_BYTES),
        .FETCH_BYTES (FETCH_BYTES),
        .MAX_INS     (MAX_INS)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .pop_en     (fire),
        .pop_len    (dec_len),
        .push_en    (push),
        .push_data  (fetch_data),
        .count      (count),
        .head_bytes (win_bytes)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ins_valid_d = ins_valid_q;
        ins_out_d   = ins_out_q;
        ins_pc_d    = ins_pc_q;
        ins_len_d   = ins_len_q;
        if (redirect) begin
            state_d     = RUN;
            pc_d        = redirect_pc;
            ins_valid_d = 1'b0;
        end else begin
            if (fire) begin
                ins_valid_d = 1'b1;
                ins_out_d   = dec_ins;
                ins_pc_d    = pc_q;
                ins_len_d   = dec_len;
                pc_d        = pc_q + 64'(dec_len);
            end else if (ins_valid_q && ins_ready) begin
                ins_valid_d = 1'b0;
            end
            if (fault) begin
                state_d = HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            pc_q        <= '0;
            ins_valid_q <= 1'b0;
            ins_out_q   <= '0;
            ins_pc_q    <= '0;
            ins_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_valid_q <= ins_valid_d;
            ins_out_q   <= ins_out_d;
            ins_pc_q    <= ins_pc_d;
            ins_len_q   <= ins_len_d;
        end
    end

    assign win_count = (count >= CNT_W'(MAX_INS)) ? 6'(MAX_INS) : 6'(count);
    assign ins_valid = ins_valid_q;
    assign ins_out   = ins_out_q;
    assign ins_pc    = ins_pc_q;
    assign ins_len   = ins_len_q;
    assign halted    = (state_q == HALT);

endmodule
`default_nettype wire

// File: tb/tb_decode_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_byte_sequencer
// Description : Directed plus random bench with a byte-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_byte_sequencer;
    import DecoderTypes::*;

    localparam int FB = 8;
    localparam int MI = 15;

    typedef struct packed {
        logic [63:0]      pc;
        logic [3:0]       len;
        fat_instruction_t ins;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset, redirect, fetch_valid, fetch_ready;
    logic [63:0]      redirect_pc;
    logic [FB*8-1:0]  fetch_data;
    logic [MI*8-1:0]  win_bytes;
    logic [5:0]       win_count;
    logic             dec_need_more, dec_err, ins_valid, ins_ready, halted;
    logic [3:0]       dec_len, ins_len;
    fat_instruction_t dec_ins, ins_out;
    logic [63:0]      ins_pc;

    int   total = 0;
    int   bad   = 0;
    bit   err_en = 1'b0;
    bit   last_acc;

    logic [7:0]  stream_q [$];
    exp_t        exp_q    [$];
    logic [63:0] m_pc;
    bit          m_halt;

    logic [63:0] beat_b, beat_c;

    always #5 clk = ~clk;

    decode_byte_sequencer #(.BUF_BYTES(32), .FETCH_BYTES(FB), .MAX_INS(MI)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_data(fetch_data), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .win_bytes(win_bytes), .win_count(win_count),
        .dec_need_more(dec_need_more), .dec_err(dec_err), .dec_len(dec_len), .dec_ins(dec_ins),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_out(ins_out),
        .ins_pc(ins_pc), .ins_len(ins_len), .halted(halted)
    );

    // Toy ISA: length from the first byte; 0xCC is illegal when err_en is set.
    function automatic int len_of(input logic [7:0] b);
        if (b == 8'h48) return 10;
        if (b == 8'h0F) return 8;
        return int'(b[1:0]) + 1;
    endfunction

    function automatic fat_instruction_t mk_ins(input logic [7:0] op, input logic [63:0] imm);
        fat_instruction_t f;
        f        = '0;
        f.opcode = op;
        f.imm    = imm;
        return f;
    endfunction

    logic [7:0]  w0;
    int          wl;
    logic [63:0] wimm;
    always_comb begin
        w0   = win_bytes[MI*8-1 -: 8];
        wl   = len_of(w0);
        wimm = '0;
        for (int k = 1; k <= 8; k++) begin
            if (k < wl) wimm[64-8*k +: 8] = win_bytes[(MI-1-k)*8 +: 8];
        end
        dec_len       = 4'(wl);
        dec_need_more = (wl > int'(win_count));
        dec_err       = err_en && (w0 == 8'hCC) && (win_count != 6'd0);
        dec_ins       = mk_ins(w0, wimm);
    end

    function automatic void parse();
        while (!m_halt && stream_q.size() > 0) begin
            logic [7:0]  op;
            int          l;
            logic [63:0] imm;
            exp_t        e;
            op = stream_q[0];
            if (err_en && op == 8'hCC) begin
                m_halt = 1'b1;
                break;
            end
            l = len_of(op);
            if (stream_q.size() < l) break;
            imm = '0;
            for (int k = 1; k <= 8; k++) begin
                if (k < l) imm[64-8*k +: 8] = stream_q[k];
            end
            e.pc  = m_pc;
            e.len = 4'(l);
            e.ins = mk_ins(op, imm);
            exp_q.push_back(e);
            for (int k = 0; k < l; k++) void'(stream_q.pop_front());
            m_pc = m_pc + 64'(l);
        end
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score the handshake and update the model at negedge, return at posedge+1.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (ins_valid && ins_ready && !redirect && !reset) begin
            check("sb_pop_expected", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc", ins_pc, e.pc);
                check("sb_len", ins_len, e.len);
                check("sb_ins", ins_out, e.ins);
            end
        end
        last_acc = 1'b0;
        if (reset) begin
            stream_q.delete(); exp_q.delete(); m_pc = '0; m_halt = 1'b0;
        end else if (redirect) begin
            stream_q.delete(); exp_q.delete(); m_pc = redirect_pc; m_halt = 1'b0;
        end else if (fetch_valid && fetch_ready) begin
            for (int k = 0; k < FB; k++) stream_q.push_back(fetch_data[63-8*k -: 8]);
            parse();
            last_acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [63:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        cyc();
        redirect    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
        fetch_data = '0; fetch_valid = 1'b0; ins_ready = 1'b0;
        cyc(); cyc();
        check("rst_valid", ins_valid, 0);
        check("rst_count", win_count, 0);
        check("rst_fready", fetch_ready, 1);
        check("rst_halted", halted, 0);
        check("rst_pc", ins_pc, 0);
        check("rst_len", ins_len, 0);
        check("rst_ins", ins_out, 0);
        reset = 1'b0;

        // Eight one-byte NOPs, one per cycle.
        ins_ready = 1'b1;
        fetch_data = 64'h9090_9090_9090_9090; fetch_valid = 1'b1;
        cyc(); fetch_valid = 1'b0;
        check("nop_count", win_count, 8);
        check("nop_latency", ins_valid, 0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("nop_valid", ins_valid, 1);
            check("nop_pc", ins_pc, 64'(i));
        end
        check("nop_empty", win_count, 0);
        cyc();
        check("nop_idle", ins_valid, 0);

        // MOV r64,imm64 split across two beats.
        do_redirect(64'h40_0000);
        check("mov_flush", win_count, 0);
        fetch_data = {8'h48, 8'hB8, 48'h11_2233_4455_66}; fetch_valid = 1'b1;
        cyc(); fetch_valid = 1'b0;
        check("mov_count8", win_count, 8);
        cyc();
        check("mov_need_more", ins_valid, 0);
        check("mov_hold8", win_count, 8);
        fetch_data = {16'h7788, 48'h9090_9090_9090}; fetch_valid = 1'b1;
        cyc(); fetch_valid = 1'b0;
        check("mov_count16", win_count, 15);
        cyc();
        check("mov_valid", ins_valid, 1);
        check("mov_len", ins_len, 10);
        check("mov_pc", ins_pc, 64'h40_0000);
        check("mov_imm", ins_out.imm, 64'hB811_2233_4455_6677);
        check("mov_rest", win_count, 6);
        cyc();
        check("mov_next_pc", ins_pc, 64'h40_000A);
        repeat (6) cyc();

        // Backpressure until the buffer is full.
        ins_ready = 1'b0;
        do_redirect(64'h2000);
        fetch_data = {8'h0F, 24'($urandom), 32'($urandom)}; fetch_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (last_acc) fetch_data = {32'($urandom), 32'($urandom)};
        end
        check("full_fready", fetch_ready, 0);
        check("full_win", win_count, 15);
        check("full_valid", ins_valid, 1);
        check("full_pc", ins_pc, 64'h2000);
        check("full_len", ins_len, 8);
        repeat (3) cyc();
        check("full_hold", ins_valid, 1);
        ins_ready = 1'b1; fetch_valid = 1'b0;
        repeat (40) cyc();
        check("full_drained", 128'(exp_q.size()), 0);

        // Decode error on the third instruction.
        err_en = 1'b1;
        do_redirect(64'h3000);
        fetch_data = 64'h9090_CC90_9090_9090; fetch_valid = 1'b1;
        cyc(); fetch_valid = 1'b0;
        cyc();
        check("err_pc0", ins_pc, 64'h3000);
        check("err_not_halted", halted, 0);
        cyc();
        check("err_pc1", ins_pc, 64'h3001);
        cyc();
        check("err_halted", halted, 1);
        check("err_valid", ins_valid, 0);
        check("err_win", win_count, 6);
        check("err_byte", win_bytes[MI*8-1 -: 8], 8'hCC);
        fetch_data = {32'($urandom), 32'($urandom)}; fetch_valid = 1'b1;
        cyc(); fetch_valid = 1'b0;
        check("halt_fill", win_count, 14);
        repeat (2) cyc();
        check("halt_no_fire", ins_valid, 0);
        check("halt_sticky", halted, 1);
        do_redirect(64'h1000);
        check("redir_halted", halted, 0);
        check("redir_count", win_count, 0);
        check("redir_valid", ins_valid, 0);
        err_en = 1'b0;

        // Push and fire in the same cycle, then redirect over push and fire.
        do_redirect(64'h5000);
        fetch_data = {8'h01, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h02, 8'h44}; fetch_valid = 1'b1;
        cyc(); fetch_valid = 1'b0;
        cyc();
        check("same_c6", win_count, 6);
        beat_b = {32'($urandom), 32'($urandom)};
        beat_b[55:48] = 8'h90;
        fetch_data = beat_b; fetch_valid = 1'b1;
        cyc();
        check("same_c10", win_count, 10);
        check("same_len4", ins_len, 4);
        beat_c = {32'($urandom), 32'($urandom)};
        fetch_data = beat_c;
        cyc(); fetch_valid = 1'b0;
        check("same_c15", win_count, 15);
        check("same_len3", ins_len, 3);
        check("same_pc", ins_pc, 64'h5006);
        check("same_order", win_bytes, {beat_b[55:0], beat_c});
        fetch_data = {32'($urandom), 32'($urandom)}; fetch_valid = 1'b1;
        do_redirect(64'h6000);
        fetch_valid = 1'b0;
        check("rd_count", win_count, 0);
        check("rd_valid", ins_valid, 0);
        cyc();
        check("rd_no_fire", ins_valid, 0);
        fetch_data = 64'h9090_9090_9090_9090; fetch_valid = 1'b1;
        cyc(); fetch_valid = 1'b0;
        cyc();
        check("rd_new_pc", ins_pc, 64'h6000);
        repeat (8) cyc();

        // Reset mid-operation.
        ins_ready = 1'b0;
        do_redirect(64'h7000);
        fetch_data = {8'h03, 24'($urandom), 32'($urandom)}; fetch_valid = 1'b1;
        cyc();
        fetch_data = {32'($urandom), 32'($urandom)};
        cyc();
        fetch_data = {32'($urandom), 32'($urandom)};
        cyc(); fetch_valid = 1'b0;
        check("mid_valid", ins_valid, 1);
        check("mid_win", win_count, 15);
        check("mid_fready", fetch_ready, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mid_rst_valid", ins_valid, 0);
        check("mid_rst_count", win_count, 0);
        check("mid_rst_fready", fetch_ready, 1);
        check("mid_rst_pc", ins_pc, 0);
        ins_ready = 1'b1;
        fetch_data = 64'h9090_9090_9090_9090; fetch_valid = 1'b1;
        cyc(); fetch_valid = 1'b0;
        cyc(); cyc();
        check("mid_rst_pc1", ins_pc, 64'h1);
        repeat (8) cyc();

        // Random traffic, including a PC wrap through zero.
        do_redirect(64'hFFFF_FFFF_FFFF_FFFA);
        for (int i = 0; i < 400; i++) begin
            fetch_data  = {32'($urandom), 32'($urandom)};
            fetch_valid = 1'($urandom_range(0, 1));
            ins_ready   = ($urandom_range(0, 3) != 0);
            if (i % 100 == 99) begin
                do_redirect({32'($urandom), 32'($urandom)});
            end else begin
                cyc();
            end
        end
        fetch_valid = 1'b0; ins_ready = 1'b1;
        repeat (40) cyc();
        check("rand_drained", 128'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
